// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN filter datapath.
// Holds the default filter geometry and the filter_bank_buffer
// sequencing state type.
package cnn_pkg;

    localparam int unsigned DEFAULT_DATA_W   = 16;
    localparam int unsigned DEFAULT_KSIZE    = 5;
    localparam int unsigned DEFAULT_NUM_FILT = 6;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FETCH,
        ST_PRESENT,
        ST_DONE
    } fbb_state_t;

endpackage

// File: rtl/filter_bank_buffer_mem.sv
// filter_mem: storage for NUM_FILT filters of TAPS words each.
// Ports:
//   clk   - write clock
//   we    - write enable for one word
//   waddr - flat word index (filter-major, then tap-major)
//   wdata - word to store
//   rsel  - filter number to read
//   rdata - all TAPS words of filter rsel, tap k at [k*DATA_W +: DATA_W]
// The contents are never reset.
module filter_mem #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TAPS     = 25,
    parameter int unsigned NUM_FILT = 6,
    localparam int unsigned DEPTH   = NUM_FILT * TAPS,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned IW      = $clog2(NUM_FILT)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [IW-1:0]            rsel,
    output logic [TAPS*DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            rdata[k*DATA_W +: DATA_W] = mem[AW'(rsel * TAPS + k)];
        end
    end

endmodule

// File: rtl/filter_bank_buffer.sv
// filter_bank_buffer: loads NUM_FILT filters of KSIZE*KSIZE taps as a
// word stream, then presents them one whole filter at a time.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clear        - synchronous flush back to loading (storage kept)
//   wr_valid/wr_ready/wr_data - tap word input stream
//   rd_valid/rd_ready         - filter output handshake
//   rd_filter    - presented filter, tap k at [k*DATA_W +: DATA_W]
//   rd_index     - number of the presented filter
//   rewind       - after the last filter, replay from filter 0
//   loaded       - all filters stored
//   empty        - every filter consumed since load/rewind
module filter_bank_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned KSIZE    = DEFAULT_KSIZE,
    parameter int unsigned NUM_FILT = DEFAULT_NUM_FILT,
    localparam int unsigned TAPS    = KSIZE * KSIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [TAPS*DATA_W-1:0]        rd_filter,
    output logic [$clog2(NUM_FILT)-1:0]   rd_index,
    input  logic                          rewind,
    output logic                          loaded,
    output logic                          empty
);

    localparam int unsigned DEPTH = NUM_FILT * TAPS;
    localparam int unsigned PW    = $clog2(DEPTH + 1);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned IW    = $clog2(NUM_FILT);

    fbb_state_t           state, state_d;
    logic [PW-1:0]        wr_ptr, wr_ptr_d;
    logic [IW-1:0]        rd_ptr, rd_ptr_d;
    logic                 loaded_d, empty_d;
    logic                 fetch;
    logic                 wr_en;
    logic [TAPS*DATA_W-1:0] mem_rdata;

    assign wr_ready = (state == ST_LOAD);
    assign rd_valid = (state == ST_PRESENT);
    // clear must block a write that coincides with it
    assign wr_en    = wr_ready && wr_valid && !clear;

    filter_mem #(
        .DATA_W   (DATA_W),
        .TAPS     (TAPS),
        .NUM_FILT (NUM_FILT)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .rsel  (rd_ptr),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d  = state;
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        loaded_d = loaded;
        empty_d  = empty;
        fetch    = 1'b0;
        if (clear) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            loaded_d = 1'b0;
            empty_d  = 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (wr_valid) begin
                        wr_ptr_d = wr_ptr + PW'(1);
                        if (wr_ptr == PW'(DEPTH - 1)) begin
                            // a fresh load has nothing consumed yet
                            loaded_d = 1'b1;
                            empty_d  = 1'b0;
                            rd_ptr_d = '0;
                            state_d  = ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    fetch   = 1'b1;
                    state_d = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (rd_ready) begin
                        if (rd_ptr == IW'(NUM_FILT - 1)) begin
                            empty_d = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            rd_ptr_d = rd_ptr + IW'(1);
                            state_d  = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    if (rewind) begin
                        empty_d  = 1'b0;
                        rd_ptr_d = '0;
                        state_d  = ST_FETCH;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            loaded    <= 1'b0;
            empty     <= 1'b1;
            rd_index  <= '0;
            rd_filter <= '0;
        end else begin
            state  <= state_d;
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            loaded <= loaded_d;
            empty  <= empty_d;
            if (fetch) begin
                rd_filter <= mem_rdata;
                rd_index  <= rd_ptr;
            end
        end
    end

endmodule

// File: tb/tb_filter_bank_buffer.sv
module tb_filter_bank_buffer;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned KSIZE    = 5;
    localparam int unsigned NUM_FILT = 6;
    localparam int unsigned TAPS     = KSIZE * KSIZE;
    localparam int unsigned DEPTH    = NUM_FILT * TAPS;
    localparam int unsigned IW       = $clog2(NUM_FILT);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   clear = 1'b0;
    logic                   wr_valid = 1'b0;
    logic                   wr_ready;
    logic [DATA_W-1:0]      wr_data = '0;
    logic                   rd_valid;
    logic                   rd_ready = 1'b0;
    logic [TAPS*DATA_W-1:0] rd_filter;
    logic [IW-1:0]          rd_index;
    logic                   rewind = 1'b0;
    logic                   loaded;
    logic                   empty;

    int checks = 0;
    int errors = 0;

    filter_bank_buffer #(
        .DATA_W   (DATA_W),
        .KSIZE    (KSIZE),
        .NUM_FILT (NUM_FILT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_filter (rd_filter),
        .rd_index  (rd_index),
        .rewind    (rewind),
        .loaded    (loaded),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] tap(input int unsigned k);
        return rd_filter[k*DATA_W +: DATA_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n words of value base+i; checks loaded goes high only on the last word.
    task automatic load_words(input int unsigned base, input int unsigned n, input logic full);
        for (int unsigned i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = DATA_W'(base + i);
            if (full && i == DEPTH - 1) begin
                chk("wr_ready_last_word", 32'(wr_ready), 32'd1);
                chk("loaded_before_last", 32'(loaded), 32'd0);
            end
            tick();
        end
        wr_valid = 1'b0;
    endtask

    typedef struct {
        logic        rdy, rew, wv;
        logic        rv, wrdy, emp;
        int unsigned idx, tap0, tapl;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rew, input logic wv,
                                input logic rv, input logic wrdy, input logic emp,
                                input int unsigned idx, input int unsigned tap0,
                                input int unsigned tapl);
        vec_t v;
        v.rdy = rdy; v.rew = rew; v.wv = wv;
        v.rv = rv; v.wrdy = wrdy; v.emp = emp;
        v.idx = idx; v.tap0 = tap0; v.tapl = tapl;
        return v;
    endfunction

    vec_t tbl[27];

    initial begin
        // Read-phase vectors: outputs checked for the current cycle with the row's
        // inputs applied, then one clock edge. Starts in FETCH of filter 0.
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,   0,   0);
        tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0,   0,  24);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0,   0,  24);
        tbl[3]  = mk(1, 0, 0, 1, 0, 0, 1,  25,  49);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 1,  25,  49);
        for (int r = 5; r <= 14; r++)
            tbl[r] = mk(0, 0, 0, 1, 0, 0, 2, 50, 74);
        tbl[15] = mk(1, 0, 0, 1, 0, 0, 2,  50,  74);
        tbl[16] = mk(1, 0, 0, 0, 0, 0, 2,  50,  74);
        tbl[17] = mk(1, 0, 0, 1, 0, 0, 3,  75,  99);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 3,  75,  99);
        tbl[19] = mk(1, 0, 0, 1, 0, 0, 4, 100, 124);
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 4, 100, 124);
        tbl[21] = mk(1, 0, 0, 1, 0, 0, 5, 125, 149);
        tbl[22] = mk(0, 0, 1, 0, 0, 1, 5, 125, 149);
        tbl[23] = mk(0, 1, 1, 0, 0, 1, 5, 125, 149);
        tbl[24] = mk(0, 0, 1, 0, 0, 0, 5, 125, 149);
        tbl[25] = mk(0, 1, 0, 1, 0, 0, 0,   0,  24);
        tbl[26] = mk(0, 0, 0, 1, 0, 0, 0,   0,  24);

        // Reset state
        #12;
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_rd_index", 32'(rd_index), 32'd0);
        chk("rst_tap0", 32'(tap(0)), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

        // Full load, value = index
        load_words(0, DEPTH, 1'b1);
        chk("loaded_after_load", 32'(loaded), 32'd1);
        chk("wr_ready_after_load", 32'(wr_ready), 32'd0);

        for (int r = 0; r < 27; r++) begin
            rd_ready = tbl[r].rdy;
            rewind   = tbl[r].rew;
            wr_valid = tbl[r].wv;
            wr_data  = 16'hdead;
            #1;
            chk($sformatf("row%0d_rd_valid", r), 32'(rd_valid), 32'(tbl[r].rv));
            chk($sformatf("row%0d_wr_ready", r), 32'(wr_ready), 32'(tbl[r].wrdy));
            chk($sformatf("row%0d_empty", r), 32'(empty), 32'(tbl[r].emp));
            chk($sformatf("row%0d_loaded", r), 32'(loaded), 32'd1);
            chk($sformatf("row%0d_rd_index", r), 32'(rd_index), tbl[r].idx);
            chk($sformatf("row%0d_tap0", r), 32'(tap(0)), tbl[r].tap0);
            chk($sformatf("row%0d_tap24", r), 32'(tap(TAPS-1)), tbl[r].tapl);
            tick();
        end
        rd_ready = 1'b0;
        rewind   = 1'b0;
        wr_valid = 1'b0;

        // clear from PRESENT, with a coincident write
        clear = 1'b1; wr_valid = 1'b1; wr_data = 16'h5555;
        tick();
        clear = 1'b0; wr_valid = 1'b0;
        chk("clr1_wr_ready", 32'(wr_ready), 32'd1);
        chk("clr1_rd_valid", 32'(rd_valid), 32'd0);
        chk("clr1_loaded", 32'(loaded), 32'd0);
        chk("clr1_empty", 32'(empty), 32'd1);

        // Partial load then clear (clear wins over the write)
        load_words(2000, 40, 1'b0);
        chk("partial_loaded", 32'(loaded), 32'd0);
        clear = 1'b1; wr_valid = 1'b1; wr_data = 16'h7777;
        tick();
        clear = 1'b0; wr_valid = 1'b0;
        chk("clr2_wr_ready", 32'(wr_ready), 32'd1);
        chk("clr2_loaded", 32'(loaded), 32'd0);
        chk("clr2_empty", 32'(empty), 32'd1);

        // Reload from index 0 with value 1000+index
        load_words(1000, DEPTH, 1'b1);
        chk("reload_loaded", 32'(loaded), 32'd1);
        tick();
        chk("reload_f0_valid", 32'(rd_valid), 32'd1);
        chk("reload_f0_index", 32'(rd_index), 32'd0);
        chk("reload_f0_tap0", 32'(tap(0)), 32'd1000);
        chk("reload_f0_tap24", 32'(tap(TAPS-1)), 32'd1024);
        rd_ready = 1'b1;
        tick();
        tick();
        chk("reload_f1_index", 32'(rd_index), 32'd1);
        chk("reload_f1_tap0", 32'(tap(0)), 32'd1025);
        tick(); tick(); tick(); tick();
        rd_ready = 1'b0;
        chk("reload_f3_valid", 32'(rd_valid), 32'd1);
        chk("reload_f3_index", 32'(rd_index), 32'd3);
        chk("reload_f3_tap0", 32'(tap(0)), 32'd1075);

        // Asynchronous reset during PRESENT of filter 3
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        chk("arst_loaded", 32'(loaded), 32'd0);
        chk("arst_rd_index", 32'(rd_index), 32'd0);
        chk("arst_tap0", 32'(tap(0)), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("release_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        chk("release2_wr_ready", 32'(wr_ready), 32'd1);
        chk("release2_rd_valid", 32'(rd_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_bank_buffer.md
FILTER_BANK_BUFFER -- requirements
Module: filter_bank_buffer

Interface
REQ-001 Parameter DATA_W, default 16, width of one filter tap word.
REQ-002 Parameter KSIZE, default 5, kernel side; TAPS = KSIZE*KSIZE (25).
REQ-003 Parameter NUM_FILT, default 6, number of filters held; depth = NUM_FILT*TAPS (150) words.
REQ-004 Port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port clear  in  1  synchronous flush; returns the block to LOAD.
REQ-007 Port wr_valid  in  1  wr_data holds a tap word.
REQ-008 Port wr_ready  out  1  block accepts a tap word this cycle.
REQ-009 Port wr_data  in  DATA_W  tap word, filter-major then tap-major order.
REQ-010 Port rd_valid  out  1  rd_filter/rd_index hold a complete filter.
REQ-011 Port rd_ready  in  1  consumer takes the presented filter.
REQ-012 Port rd_filter  out  TAPS*DATA_W  tap k at bits [k*DATA_W +: DATA_W].
REQ-013 Port rd_index  out  $clog2(NUM_FILT)  filter number being presented.
REQ-014 Port rewind  in  1  replay the loaded filters from filter 0 without reloading.
REQ-015 Port loaded  out  1  all NUM_FILT filters are stored.
REQ-016 Port empty  out  1  every loaded filter has been consumed since load/rewind.

Function
REQ-017 The block SHALL implement states LOAD, FETCH, PRESENT, DONE.
REQ-018 LOAD: wr_ready=1; each wr_valid&wr_ready SHALL store wr_data at flat index wr_ptr and increment wr_ptr.
REQ-019 Accepting word depth-1 SHALL set loaded=1, clear rd_ptr to 0, and enter FETCH next cycle.
REQ-020 FETCH: the TAPS words of filter rd_ptr SHALL be registered into rd_filter and rd_index=rd_ptr; next state PRESENT.
REQ-021 PRESENT: rd_valid=1; rd_filter, rd_index SHALL stay stable until rd_valid&rd_ready.
REQ-022 Handshake in PRESENT with rd_ptr<NUM_FILT-1 SHALL increment rd_ptr and enter FETCH (one filter per 2 cycles max).
REQ-023 Handshake in PRESENT with rd_ptr=NUM_FILT-1 SHALL enter DONE and set empty=1.
REQ-024 DONE: rewind=1 SHALL clear empty, set rd_ptr=0, enter FETCH.
REQ-025 wr_ready SHALL be 0 outside LOAD; wr_valid outside LOAD SHALL be ignored, storage unchanged.
REQ-026 rewind outside DONE SHALL be ignored.
REQ-027 clear in any state SHALL zero wr_ptr, rd_ptr, loaded, rd_valid, set empty=1, enter LOAD; clear wins over rewind, write or read handshake in the same cycle.
REQ-028 clear SHALL NOT zero filter storage; stale words are overwritten by the next load.
REQ-029 Pointers SHALL never wrap; wr_ptr saturates at depth via the LOAD->FETCH transition.

Reset
REQ-030 rst_n low SHALL asynchronously force state LOAD, wr_ptr=0, rd_ptr=0, loaded=0, empty=1, rd_valid=0, rd_index=0, rd_filter=0.
REQ-031 Filter storage SHALL NOT be reset.
REQ-032 Reset asserted mid-load or mid-read SHALL abort the operation; outputs match REQ-030 while rst_n is low.
REQ-033 wr_ready SHALL assert in the first cycle after rst_n deasserts.

Structure
REQ-034 Default DATA_W, KSIZE, NUM_FILT and the state enum SHALL live in the shared package cnn_pkg.
REQ-035 Storage SHALL be one sub-module, filter_mem (1 write word port, 1 TAPS-wide read port), instantiated once.

Verification
REQ-036 Load 150 words, value = index -> loaded=1 after word 149; filter 0 presented: tap0=0, tap24=24, rd_index=0.
REQ-037 rd_ready=1 continuously -> rd_index 0..5 each with rd_valid 1 cycle in 2; filter 5 tap0=125; then empty=1, state DONE.
REQ-038 rd_ready=0 for 10 cycles while PRESENT filter 2 -> rd_filter tap0 stays 50, rd_valid stays 1.
REQ-039 In DONE pulse rewind -> filter 0 re-presented with tap0=0, empty=0; wr_valid during this ignored (wr_ready=0).
REQ-040 clear after 40 words loaded -> wr_ptr=0, loaded=0; reload 150 words value=1000+index -> filter 1 tap0=1025.
REQ-041 rst_n low during PRESENT of filter 3 -> rd_valid=0, empty=1, wr_ready=1 immediately after release.
